// File: rtl/sample_mac_pipe_if.sv
// Handshake/data bundle for sample_mac_pipe: input beat channel plus
// result channel, both valid/ready.
interface sample_mac_pipe_if #(
  parameter int A_WIDTH = 6,
  parameter int B_WIDTH = 11,
  parameter int P_WIDTH = 11
);
  logic               in_valid;
  logic               in_ready;
  logic [A_WIDTH-1:0] din0;
  logic [B_WIDTH-1:0] din1;
  logic               mode;
  logic               first;
  logic               last;
  logic               out_valid;
  logic               out_ready;
  logic [P_WIDTH-1:0] dout;
  logic               ovf;

  modport master (
    output in_valid, din0, din1, mode, first, last, out_ready,
    input  in_ready, out_valid, dout, ovf
  );

  modport slave (
    input  in_valid, din0, din1, mode, first, last, out_ready,
    output in_ready, out_valid, dout, ovf
  );
endinterface

// File: rtl/sample_mac_pipe.sv
// Pipelined multiply / multiply-accumulate unit with valid/ready flow
// control, framed accumulation and saturating or wrapping output format.
// Latency from accepted beat to dout is NUM_STAGE cycles of advance.
module sample_mac_pipe #(
  parameter int A_WIDTH   = 6,
  parameter int B_WIDTH   = 11,
  parameter int A_SIGNED  = 0,
  parameter int B_SIGNED  = 1,
  parameter int P_WIDTH   = 11,
  parameter int ACC_WIDTH = 24,
  parameter int NUM_STAGE = 3,
  parameter int SAT_EN    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  sample_mac_pipe_if.slave bus
);
  localparam int EXT_W = A_WIDTH + B_WIDTH + 1;
  localparam int TOP   = NUM_STAGE - 1;

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [P_WIDTH-1:0]   P_MAX   = {1'b0, {(P_WIDTH-1){1'b1}}};
  localparam logic [P_WIDTH-1:0]   P_MIN   = {1'b1, {(P_WIDTH-1){1'b0}}};

  typedef struct packed {
    logic mode;
    logic first;
    logic last;
  } ctrl_t;

  logic                      adv;
  logic                      out_valid_q;
  logic [P_WIDTH-1:0]        dout_q;
  logic                      ovf_q;

  logic signed [EXT_W-1:0]   a_ext, b_ext;
  logic signed [EXT_W-1:0]   a_s1, b_s1;
  logic signed [EXT_W-1:0]   prod_s1;
  logic [TOP:1]              vld_pipe;
  ctrl_t [TOP:1]             ctrl_pipe;
  logic [TOP:2][EXT_W-1:0]   prod_pipe;

  logic signed [ACC_WIDTH-1:0] acc_q, acc_base, acc_nxt, p_t, fmt_in;
  logic signed [ACC_WIDTH:0]   sum;
  logic [ACC_WIDTH-P_WIDTH:0]  fmt_hi;
  logic                        acc_ovf, sticky_q, sticky_nxt;
  logic                        fmt_ovf, ovf_nxt, emit;
  logic [P_WIDTH-1:0]          fmt_val;
  ctrl_t                       c_t;
  logic                        v_t;

  // One global advance: a held output or ce=0 freezes every stage.
  assign adv          = ce && (!out_valid_q || bus.out_ready);
  assign bus.in_ready = adv && reset;
  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.ovf       = ovf_q;

  // Extend operands so the product is exact in EXT_W signed bits.
  generate
    if (A_SIGNED != 0) begin : g_a_s
      assign a_ext = {{(EXT_W-A_WIDTH){bus.din0[A_WIDTH-1]}}, bus.din0};
    end else begin : g_a_u
      assign a_ext = {{(EXT_W-A_WIDTH){1'b0}}, bus.din0};
    end
    if (B_SIGNED != 0) begin : g_b_s
      assign b_ext = {{(EXT_W-B_WIDTH){bus.din1[B_WIDTH-1]}}, bus.din1};
    end else begin : g_b_u
      assign b_ext = {{(EXT_W-B_WIDTH){1'b0}}, bus.din1};
    end
  endgenerate

  // Product magnitude always fits EXT_W, so the low bits are the exact value.
  assign prod_s1 = a_s1 * b_s1;

  // Operand/control capture, product register and plain delay stages.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe  <= '0;
      ctrl_pipe <= '0;
      a_s1      <= '0;
      b_s1      <= '0;
      prod_pipe <= '0;
    end else if (adv) begin
      vld_pipe[1]  <= bus.in_valid;
      ctrl_pipe[1] <= '{mode: bus.mode, first: bus.first, last: bus.last};
      a_s1         <= a_ext;
      b_s1         <= b_ext;
      vld_pipe[2]  <= vld_pipe[1];
      ctrl_pipe[2] <= ctrl_pipe[1];
      prod_pipe[2] <= prod_s1;
      for (int k = 3; k <= TOP; k++) begin
        vld_pipe[k]  <= vld_pipe[k-1];
        ctrl_pipe[k] <= ctrl_pipe[k-1];
        prod_pipe[k] <= prod_pipe[k-1];
      end
    end
  end

  assign c_t = ctrl_pipe[TOP];
  assign v_t = vld_pipe[TOP];
  assign p_t = ACC_WIDTH'($signed(prod_pipe[TOP]));

  // Final stage: accumulate with overflow detection, then format to P_WIDTH.
  always_comb begin
    acc_base   = c_t.first ? '0 : acc_q;
    sum        = (ACC_WIDTH+1)'(acc_base) + (ACC_WIDTH+1)'(p_t);
    acc_ovf    = sum[ACC_WIDTH] != sum[ACC_WIDTH-1];
    acc_nxt    = sum[ACC_WIDTH-1:0];
    if (acc_ovf && SAT_EN != 0) acc_nxt = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    sticky_nxt = (c_t.first ? 1'b0 : sticky_q) | acc_ovf;

    fmt_in  = c_t.mode ? acc_nxt : p_t;
    fmt_hi  = fmt_in[ACC_WIDTH-1:P_WIDTH-1];
    fmt_ovf = !((&fmt_hi) || !(|fmt_hi));
    fmt_val = fmt_in[P_WIDTH-1:0];
    if (fmt_ovf && SAT_EN != 0) fmt_val = fmt_in[ACC_WIDTH-1] ? P_MIN : P_MAX;

    emit    = v_t && (!c_t.mode || c_t.last);
    ovf_nxt = fmt_ovf || (c_t.mode && sticky_nxt);
  end

  // Output register and accumulator; bubbles and MUL beats leave acc alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      ovf_q       <= 1'b0;
    end else if (adv) begin
      out_valid_q <= emit;
      if (emit) begin
        dout_q <= fmt_val;
        ovf_q  <= ovf_nxt;
      end
      if (v_t && c_t.mode) begin
        acc_q    <= acc_nxt;
        sticky_q <= sticky_nxt;
      end
    end
  end
endmodule

// File: tb/tb_sample_mac_pipe.sv
// Bench for sample_mac_pipe: a saturating and a wrapping instance share one
// stimulus stream; a scoreboard predicts each result from plain arithmetic.
module tb_sample_mac_pipe;
  localparam int AW = 6, BW = 11, PW = 11, AC = 24, NS = 3;

  logic clk = 1'b0, rst_n = 1'b0, ce = 1'b0;
  logic in_valid = 1'b0, mode = 1'b0, first = 1'b0, last = 1'b0, out_ready = 1'b0;
  logic [AW-1:0] din0 = '0;
  logic [BW-1:0] din1 = '0;
  int cyc = 0, n_cmp = 0, n_err = 0, n_out = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sample_mac_pipe_if #(.A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW)) bs ();
  sample_mac_pipe_if #(.A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW)) bw ();

  assign bs.in_valid = in_valid;  assign bw.in_valid = in_valid;
  assign bs.din0 = din0;          assign bw.din0 = din0;
  assign bs.din1 = din1;          assign bw.din1 = din1;
  assign bs.mode = mode;          assign bw.mode = mode;
  assign bs.first = first;        assign bw.first = first;
  assign bs.last = last;          assign bw.last = last;
  assign bs.out_ready = out_ready; assign bw.out_ready = out_ready;

  sample_mac_pipe #(.A_WIDTH(AW), .B_WIDTH(BW), .A_SIGNED(0), .B_SIGNED(1), .P_WIDTH(PW),
    .ACC_WIDTH(AC), .NUM_STAGE(NS), .SAT_EN(1)) u_sat (.clk(clk), .reset(rst_n), .ce(ce), .bus(bs));
  sample_mac_pipe #(.A_WIDTH(AW), .B_WIDTH(BW), .A_SIGNED(0), .B_SIGNED(1), .P_WIDTH(PW),
    .ACC_WIDTH(AC), .NUM_STAGE(NS), .SAT_EN(0)) u_wrap (.clk(clk), .reset(rst_n), .ce(ce), .bus(bw));

  // ---------------- reference model ----------------
  typedef struct packed { logic [PW-1:0] d; logic o; } exp_t;
  exp_t q0[$];   // wrapping instance
  exp_t q1[$];   // saturating instance
  longint macc [2];
  bit     mstk [2];

  function automatic longint wrapw(longint x, int w);
    longint m = longint'(1) <<< w;
    return ((x % m) + m + m / 2) % m - m / 2;
  endfunction

  function automatic exp_t fmt(longint x, bit sat);
    exp_t r;
    longint y;
    longint hi = (longint'(1) <<< (PW - 1)) - 1;
    longint lo = -hi - 1;
    r.o = (x > hi) || (x < lo);
    if (!r.o) y = x;
    else if (sat) y = (x > hi) ? hi : lo;
    else y = wrapw(x, PW);
    r.d = y[PW-1:0];
    return r;
  endfunction

  function automatic void push(int k, exp_t e);
    if (k == 1) q1.push_back(e); else q0.push_back(e);
  endfunction

  function automatic void model_accept();
    longint a = longint'(din0);
    longint b = longint'($signed(din1));
    longint p = a * b;
    longint amax = (longint'(1) <<< (AC - 1)) - 1;
    longint amin = -amax - 1;
    longint s;
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      bit sat = (k == 1);
      if (!mode) push(k, fmt(p, sat));
      else begin
        if (first) begin macc[k] = p; mstk[k] = 1'b0; end
        else begin
          s = macc[k] + p;
          if (s > amax || s < amin) begin
            mstk[k] = 1'b1;
            macc[k] = sat ? ((s > amax) ? amax : amin) : wrapw(s, AC);
          end else macc[k] = s;
        end
        if (last) begin
          e = fmt(macc[k], sat);
          e.o = e.o | mstk[k];
          push(k, e);
        end
      end
    end
  endfunction

  // Scoreboard: at each negedge, predict accepted beats and check consumed outputs.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q0.delete(); q1.delete();
      for (int k = 0; k < 2; k++) begin macc[k] = 0; mstk[k] = 1'b0; end
    end else begin
      if (ce && out_ready && bs.out_valid) begin
        n_out++; n_cmp++;
        if (q1.size() == 0) begin
          n_err++; $display("FAIL sat_out unexpected beat dout=%0d", $signed(bs.dout));
        end else begin
          e = q1.pop_front();
          if (bs.dout !== e.d || bs.ovf !== e.o) begin
            n_err++;
            $display("FAIL sat_out got dout=%0d ovf=%b want dout=%0d ovf=%b",
                     $signed(bs.dout), bs.ovf, $signed(e.d), e.o);
          end
        end
      end
      if (ce && out_ready && bw.out_valid) begin
        n_cmp++;
        if (q0.size() == 0) begin
          n_err++; $display("FAIL wrap_out unexpected beat dout=%0d", $signed(bw.dout));
        end else begin
          e = q0.pop_front();
          if (bw.dout !== e.d || bw.ovf !== e.o) begin
            n_err++;
            $display("FAIL wrap_out got dout=%0d ovf=%b want dout=%0d ovf=%b",
                     $signed(bw.dout), bw.ovf, $signed(e.d), e.o);
          end
        end
      end
      if (in_valid && bs.in_ready) model_accept();
    end
  end

  // ---------------- stimulus helpers ----------------
  // Present one beat from posedge+1; returns at posedge+1 after acceptance.
  task automatic send(input int a, input int b, input bit m, input bit f, input bit l);
    int guard = 0;
    in_valid = 1'b1; din0 = AW'(a); din1 = BW'(b); mode = m; first = f; last = l;
    @(negedge clk);
    while (!bs.in_ready && guard < 200) begin @(negedge clk); guard++; end
    if (guard >= 200) begin n_err++; $display("FAIL send_timeout in_ready stuck at 0, need 1"); end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid at a negedge; returns at that negedge.
  task automatic wait_out(output int t, output bit seen);
    seen = 1'b0; t = -1;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (bs.out_valid) begin seen = 1'b1; t = cyc; end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    ce = 1'b1; out_ready = 1'b1; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bs.in_ready, bs.out_valid, bs.ovf, bs.dout} !== '0) begin
      n_err++; $display("FAIL reset_sat rdy=%b vld=%b ovf=%b dout=%0d, need all 0",
                        bs.in_ready, bs.out_valid, bs.ovf, bs.dout);
    end
    n_cmp++;
    if ({bw.in_ready, bw.out_valid, bw.ovf, bw.dout} !== '0) begin
      n_err++; $display("FAIL reset_wrap rdy=%b vld=%b ovf=%b dout=%0d, need all 0",
                        bw.in_ready, bw.out_valid, bw.ovf, bw.dout);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bs.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release in_ready=%b need 1", bs.in_ready); end
  endtask

  task automatic test_mul_basic();
    int t0, t; bit seen;
    @(posedge clk); #1;
    t0 = cyc;
    send(63, -5, 1'b0, 1'b0, 1'b0);
    wait_out(t, seen);
    n_cmp++;
    if (!seen || t - t0 != 3) begin n_err++; $display("FAIL mul_latency got %0d need 3 (seen=%b)", t - t0, seen); end
    n_cmp++;
    if ($signed(bs.dout) != -315 || bs.ovf !== 1'b0 || $signed(bw.dout) != -315 || bw.ovf !== 1'b0) begin
      n_err++; $display("FAIL mul_value sat=%0d/%b wrap=%0d/%b need -315/0",
                        $signed(bs.dout), bs.ovf, $signed(bw.dout), bw.ovf);
    end
  endtask

  task automatic test_format_ovf();
    int t; bit seen;
    @(posedge clk); #1;
    send(63, 1023, 1'b0, 1'b0, 1'b0);
    wait_out(t, seen);
    n_cmp++;
    if (!seen || $signed(bs.dout) != 1023 || bs.ovf !== 1'b1) begin
      n_err++; $display("FAIL ovf_sat got %0d/%b need 1023/1", $signed(bs.dout), bs.ovf);
    end
    n_cmp++;
    if (!seen || $signed(bw.dout) != 961 || bw.ovf !== 1'b1) begin
      n_err++; $display("FAIL ovf_wrap got %0d/%b need 961/1", $signed(bw.dout), bw.ovf);
    end
  endtask

  task automatic test_mac_frame();
    int t0, t_out = -1, cnt = 0, d = 0;
    @(posedge clk); #1;
    t0 = cyc;
    send(10, 20, 1'b1, 1'b1, 1'b0);
    send(5, -3, 1'b1, 1'b0, 1'b0);
    send(2, 7, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bs.out_valid) begin cnt++; t_out = cyc; d = $signed(bs.dout); end
    end
    n_cmp++;
    if (cnt != 1) begin n_err++; $display("FAIL mac_count got %0d outputs need 1", cnt); end
    n_cmp++;
    if (t_out - t0 != 5) begin n_err++; $display("FAIL mac_latency got %0d need 5 from first beat", t_out - t0); end
    n_cmp++;
    if (d != 199) begin n_err++; $display("FAIL mac_value got %0d need 199", d); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int out0, low = 0;
    @(posedge clk); #1;
    out0 = n_out;
    out_ready = 1'b1;
    fork
      for (int i = 0; i < 8; i++) send(i, i + 1, 1'b0, 1'b0, 1'b0);
      begin
        repeat (4) @(posedge clk); #1; out_ready = 1'b0;
        repeat (5) @(posedge clk); #1; out_ready = 1'b1;
      end
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (!bs.in_ready) low++;
      end
    join
    n_cmp++;
    if (low != 5) begin n_err++; $display("FAIL b2b_stall in_ready low %0d cycles need 5", low); end
    n_cmp++;
    if (n_out - out0 != 8 || q1.size() != 0) begin
      n_err++; $display("FAIL b2b_count got %0d outputs (%0d pending) need 8 (0)", n_out - out0, q1.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midframe();
    int t; bit seen;
    @(posedge clk); #1;
    send(10, 20, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bs.out_valid !== 1'b0 || bs.in_ready !== 1'b0 || bw.out_valid !== 1'b0) begin
      n_err++; $display("FAIL midreset vld=%b rdy=%b need 0/0", bs.out_valid, bs.in_ready);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    send(3, 3, 1'b1, 1'b0, 1'b1);
    wait_out(t, seen);
    n_cmp++;
    if (!seen || $signed(bs.dout) != 9 || bs.ovf !== 1'b0 || $signed(bw.dout) != 9) begin
      n_err++; $display("FAIL midreset_value got %0d/%b need 9/0", $signed(bs.dout), bs.ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ce_freeze();
    int t0, ts [2], k = 0;
    logic [PW-1:0] d0;
    int t; bit seen;
    @(posedge clk); #1;
    out_ready = 1'b1; t0 = cyc;
    fork
      begin send(7, 9, 1'b0, 1'b0, 1'b0); send(2, -8, 1'b0, 1'b0, 1'b0); end
      begin repeat (2) @(posedge clk); #1; ce = 1'b0; repeat (4) @(posedge clk); #1; ce = 1'b1; end
    join
    ts[0] = -1; ts[1] = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bs.out_valid && k < 2) begin ts[k] = cyc - t0; k++; end
    end
    n_cmp++;
    if (ts[0] != 7 || ts[1] != 8) begin n_err++; $display("FAIL ce_offset got %0d,%0d need 7,8", ts[0], ts[1]); end

    // Held output under ce=0 with out_ready=1 must stay put.
    @(posedge clk); #1; out_ready = 1'b0;
    send(5, 5, 1'b0, 1'b0, 1'b0);
    wait_out(t, seen);
    d0 = bs.dout;
    n_cmp++;
    if (!seen || d0 !== PW'(25)) begin n_err++; $display("FAIL ce_hold_value got %0d need 25", $signed(d0)); end
    @(posedge clk); #1; ce = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bs.out_valid !== 1'b1 || bs.dout !== d0 || bs.in_ready !== 1'b0) begin
        n_err++; $display("FAIL ce_hold vld=%b dout=%0d rdy=%b need 1/25/0", bs.out_valid, $signed(bs.dout), bs.in_ready);
      end
    end
    @(posedge clk); #1; ce = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (bs.out_valid !== 1'b0) begin n_err++; $display("FAIL ce_release out_valid=%b need 0", bs.out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    @(posedge clk); #1;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      din0      = ($urandom_range(0, 3) == 0) ? AW'(63) : AW'($urandom);
      case ($urandom_range(0, 3))
        0: din1 = BW'(1023);
        1: din1 = BW'(-1024);
        default: din1 = BW'($urandom);
      endcase
      mode      = $urandom_range(0, 1) == 1;
      first     = $urandom_range(0, 3) == 0;
      last      = $urandom_range(0, 2) == 0;
      out_ready = $urandom_range(0, 3) != 0;
      ce        = $urandom_range(0, 9) != 0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; ce = 1'b1; out_ready = 1'b1;
    repeat (12) @(posedge clk); #1;
    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_err++; $display("FAIL random_drain pending wrap=%0d sat=%0d need 0/0", q0.size(), q1.size());
    end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_format_ovf();
    test_mac_frame();
    test_back_to_back();
    test_reset_midframe();
    test_ce_freeze();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end
endmodule

// File: doc/sample_mac_pipe.md
Name: sample_mac_pipe

Overview:
- Parametrised, pipelined multiply/multiply-accumulate unit. Successor to the fixed 6x11 two-stage multiplier core.
- Adds configurable operand widths and signedness, configurable pipeline depth, a valid/ready handshake with backpressure, a MAC mode with framed accumulation, and a saturating or wrapping output.
- Sits between the feature-buffer reader and the activation stage of the inference datapath.

Parameters:
- A_WIDTH, 6, width of din0.
- B_WIDTH, 11, width of din1.
- A_SIGNED, 0, 1 means din0 is two's complement; 0 means unsigned (zero-extended).
- B_SIGNED, 1, same as A_SIGNED, for din1.
- P_WIDTH, 11, width of dout. Always interpreted as signed.
- ACC_WIDTH, 24, internal accumulator width, signed. Must be >= A_WIDTH+B_WIDTH+1.
- NUM_STAGE, 3, latency in cycles from accepted input to out_valid. Must be >= 3.
- SAT_EN, 1, 1 means clamp on overflow; 0 means wrap (keep LSBs).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- ce  in  1  global enable; 0 freezes the entire pipeline.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- din0  in  A_WIDTH  operand A.
- din1  in  B_WIDTH  operand B.
- mode  in  1  per beat: 0 = MUL, 1 = MAC.
- first  in  1  MAC only: beat opens a new sum.
- last  in  1  MAC only: beat closes the sum and produces output.
- out_valid  out  1  dout valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- dout  out  P_WIDTH  result.
- ovf  out  1  qualifies dout: result was clamped (SAT_EN=1) or wrapped (SAT_EN=0).

Behaviour:
- Reset (reset=0, asynchronous): all stage-valid bits, the accumulator, dout, out_valid and ovf clear to 0. in_ready is 0 while reset is asserted. In-flight beats and any partial sum are discarded. Operation resumes on the first clk edge after release.
- Advance condition: adv = ce && (!out_valid || out_ready). in_ready = adv.
  - When adv=0, every stage holds, including the data, dout and out_valid.
- Operand extension: each operand is extended to A_WIDTH+B_WIDTH+1 bits according to A_SIGNED/B_SIGNED. The full-precision product is signed and exact, so no truncation occurs before the accumulate stage.
- Pipeline:
  - Stage 1 registers the operands and control bits.
  - Stage 2 registers the product.
  - Stages 3..NUM_STAGE-1 are delay stages.
  - Stage NUM_STAGE performs accumulate/format and drives dout/out_valid.
  - Bubbles (stages with valid=0) propagate and never alter the accumulator.
- MUL beat: dout = format(product). out_valid=1 for that beat. The accumulator is untouched.
- MAC beat:
  - If first=1, acc = product; otherwise acc = acc + product.
  - The accumulator add saturates at ACC_WIDTH when SAT_EN=1 and wraps otherwise. An accumulator overflow sets an internal sticky flag, which is cleared by the next first beat.
  - If last=0, no output is produced (out_valid stays 0 for that slot).
  - If last=1, dout = format(acc). ovf = sticky flag OR format overflow.
  - first=last=1 gives a single-beat sum equal to the product.
  - A MAC beat without a prior first adds to the surviving accumulator value (0 after reset).
- first and last are ignored on MUL beats. MUL beats may be interleaved within a MAC frame without disturbing acc.
- format(x):
  - SAT_EN=1: clamp to [-2^(P_WIDTH-1), 2^(P_WIDTH-1)-1]; ovf=1 if clamped.
  - SAT_EN=0: take the low P_WIDTH bits; ovf=1 if the value is not representable.
- Throughput: one beat per cycle when out_ready=1 and ce=1. Output order equals input order. No beat is dropped or duplicated under any stall pattern.
- Simultaneous events:
  - Output accept and new input in the same cycle are both taken.
  - ce=0 overrides out_ready: an output held with out_valid=1 stays valid and is not consumed.

Test Plan:
- Defaults, MUL, din0=63, din1=-5 at cycle 0, out_ready=1 -> out_valid at cycle 3, dout=-315, ovf=0.
- MUL, din0=63, din1=1023 -> SAT_EN=1: dout=1023, ovf=1. Rebuilt with SAT_EN=0: dout=961, ovf=1.
- MAC frame (10,20,first) (5,-3) (2,7,last) on consecutive cycles -> exactly one output, dout=199, three cycles after the last beat; no output for the first two beats.
- 8 back-to-back MUL beats (i, i+1) for i=0..7; out_ready low for cycles 4-8 -> in_ready low during the stall, then 8 outputs i*(i+1) in order, no loss or duplication.
- reset pulsed low mid-frame after (10,20,first), then (3,3,last) with no first -> out_valid=0 during reset, dout=9, ovf=0.
- ce=0 for 4 cycles with 2 beats in flight -> outputs held frozen; they resume with cycle count offset by exactly 4.
